// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file_n register file.
// Optional write-to-read bypass is selected in the top by REG_FILE_BYPASS_EN.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Minimum number of address bits needed to index n entries.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Clear sequencer: walks clr_ptr over every entry once per clear request and
// holds off writes while it runs. Outputs are registered alongside the state.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_ptr
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;
    logic              wr_ready_q, wr_ready_d;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        busy_d     = busy_q;
        wr_ready_d = wr_ready_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_ptr_d  = '0;
                    busy_d     = 1'b1;
                    wr_ready_d = 1'b0;
                end
            end
            CLEAR: begin
                // The edge that zeroes the last entry also ends the clear.
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_ptr_d  = '0;
                    busy_d     = 1'b0;
                    wr_ready_d = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                clr_ptr_d  = '0;
                busy_d     = 1'b0;
                wr_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;
    assign clr_en   = busy_q;
    assign clr_ptr  = clr_ptr_q;

endmodule

// File: rtl/reg_file_n.sv
// Register file: two combinational read ports, one handshaked write port,
// optional hard-zero entry 0, and a sequential clear. Bypass: REG_FILE_BYPASS_EN.
module reg_file_n
    import reg_file_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int HARD_ZERO = 1,
    localparam int ADDR_W    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              r_type,
    input  logic [WIDTH-1:0]  busW,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              clear_req,
    output logic              busy,
    output logic [WIDTH-1:0]  busA,
    output logic [WIDTH-1:0]  busB
);

    logic              clr_en;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] rw;
    logic              rw_ok;
    logic              wr_commit;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  clr_hit;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    reg_file_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_ready  (wr_ready),
        .clr_en    (clr_en),
        .clr_ptr   (clr_ptr)
    );

    function automatic logic addr_readable(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((HARD_ZERO != 0) && (a == '0));
    endfunction

    assign rw        = r_type ? rd : rs2;
    assign rw_ok     = addr_readable(rw);
    // Dropped writes still complete the handshake; they just never reach storage.
    assign wr_commit = wr_valid && wr_ready && rw_ok;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi]  = wr_commit && (rw == ADDR_W'(gi));
            assign clr_hit[gi] = clr_en && (clr_ptr == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_hit[i] || clr_hit[i]) begin
                mem_d[i] = clr_hit[i] ? '0 : busW;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        busA = '0;
        busB = '0;
        if (addr_readable(rs)) begin
            busA = mem_q[rs];
        end
        if (addr_readable(rs2)) begin
            busB = mem_q[rs2];
        end
`ifdef REG_FILE_BYPASS_EN
        // wr_commit is already false during a clear, so no bypass happens then.
        if (wr_commit && (rs == rw)) begin
            busA = busW;
        end
        if (wr_commit && (rs2 == rw)) begin
            busB = busW;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_n.sv
// Directed self-checking bench for reg_file_n with an abstract array model
// compared every cycle, plus literal expectations on key transactions.
module tb_reg_file_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rs2, rd;
    logic        r_type;
    logic [31:0] busW;
    logic        wr_valid, wr_ready, clear_req, busy;
    logic [31:0] busA, busB;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_mem [32];
    int          m_left = 0;   // clear cycles remaining; 0 means idle

    always #5 clk = ~clk;

    reg_file_n dut (
        .clk       (clk),
        .reset     (reset),
        .rs        (rs),
        .rs2       (rs2),
        .rd        (rd),
        .r_type    (r_type),
        .busW      (busW),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .clear_req (clear_req),
        .busy      (busy),
        .busA      (busA),
        .busB      (busB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [4:0]  w;
        logic [31:0] v;
        w = r_type ? rd : rs2;
        v = (a == 5'd0) ? 32'd0 : m_mem[a];
`ifdef REG_FILE_BYPASS_EN
        if (m_left == 0 && wr_valid && w != 5'd0 && a == w) v = busW;
`endif
        if (w == 5'd31 && a == 5'd31 && 1'b0) v = 32'd0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_mem[32 - m_left] = 32'd0;
            m_left = m_left - 1;
        end else begin
            if (wr_valid && (r_type ? rd : rs2) != 5'd0)
                m_mem[r_type ? rd : rs2] = busW;
            if (clear_req) m_left = 32;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busA", busA, m_read(rs));
            chk("model_busB", busB, m_read(rs2));
            chk("model_wr_ready", {31'd0, wr_ready}, {31'd0, m_left == 0});
            chk("model_busy", {31'd0, busy}, {31'd0, m_left != 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int a, input logic [31:0] exp);
        tick();
        rs  = 5'(a);
        rs2 = 5'(a);
        #1;
        chk($sformatf("read_A[%0d]", a), busA, exp);
        chk($sformatf("read_B[%0d]", a), busB, exp);
        $display("read  addr=%0d busA=%h busB=%h", a, busA, busB);
    endtask

    task automatic wr(input logic rt, input int dst, input logic [31:0] data);
        r_type = rt;
        if (rt) rd = 5'(dst);
        else    rs2 = 5'(dst);
        busW     = data;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        $display("write r_type=%0d dst=%0d data=%h", rt, dst, data);
    endtask

    initial begin
        int n;
        logic [31:0] exp_byp;
        reset = 1'b0; rs = '0; rs2 = '0; rd = '0; r_type = 1'b0;
        busW = '0; wr_valid = 1'b0; clear_req = 1'b0;
        tick(); tick();
        reset = 1'b1;
        chk_en = 1'b1;
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 32; a++) rd_check(a, 32'd0);

        wr(1'b1, 5, 32'hDEADBEEF);
        rs = 5'd5; rs2 = 5'd5; #1;
        chk("wb_busA", busA, 32'hDEADBEEF);
        chk("wb_busB", busB, 32'hDEADBEEF);

        wr(1'b1, 0, 32'h0000_1234);
        rs = 5'd0; #1;
        chk("hard_zero_busA", busA, 32'd0);
        wr(1'b0, 7, 32'h0000_0077);
        rs = 5'd7; #1;
        chk("rs2_dest_busA", busA, 32'h0000_0077);
        chk("rs2_dest_busB", busB, 32'h0000_0077);

`ifdef REG_FILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'd0;
`endif
        r_type = 1'b1; rd = 5'd3; busW = 32'hA5A5A5A5; wr_valid = 1'b1; rs = 5'd3; #1;
        chk("bypass_same_cycle", busA, exp_byp);
        tick();
        wr_valid = 1'b0; #1;
        chk("bypass_after_edge", busA, 32'hA5A5A5A5);

        for (int i = 1; i < 32; i++) wr(1'b1, i, 32'(i));
        r_type = 1'b1; rd = 5'd4; busW = 32'h444; wr_valid = 1'b1; clear_req = 1'b1;
        tick();
        clear_req = 1'b0; rd = 5'd9; busW = 32'h99; wr_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            chk("clear_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("clear_busy_cycles", 32'(n), 32'd32);
        $display("clear busy_cycles=%0d", n);
        for (int a = 0; a < 32; a++) rd_check(a, (a == 9) ? 32'h99 : 32'd0);

        for (int i = 1; i < 32; i++) wr(1'b1, i, 32'(i + 100));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0; rs = 5'd20;
        repeat (9) tick();
        chk("midclear_uncleared", busA, 32'd120);
        reset = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_wr_ready", {31'd0, wr_ready}, 32'd1);
        $display("reset mid-clear busy=%0d wr_ready=%0d", busy, wr_ready);
        for (int a = 0; a < 32; a++) rd_check(a, 32'd0);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
